spi_xact_arbiter: RTL

//  Shares one SPI transaction path (request queue -> SPI master -> response

---
 rtl/spi_arb_pkg.sv | 12 +
 rtl/spi_xact_arbiter_picker.sv | 29 ++
 rtl/spi_xact_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and limits for the SPI transaction arbiter slice.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } arb_state_t;

    localparam int unsigned ARB_MAX_REQ = 8;

endpackage

// File: rtl/spi_xact_arbiter_picker.sv
// Round-robin priority picker: first asserted request at or after prio, wrapping.
module rr_priority_picker
    import spi_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_prio,
    output logic [NREQ-1:0] o_win,
    output logic            o_valid
);

    logic [IW-1:0] w_idx;

    always_comb begin
        o_win   = '0;
        o_valid = 1'b0;
        w_idx   = i_prio;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!o_valid && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
            w_idx = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
        end
    end

endmodule

// File: rtl/spi_xact_arbiter.sv
// Round-robin arbiter sharing one SPI request/response queue path among NREQ requesters.
module spi_xact_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned nbits = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ*nbits-1:0] req_msg,
    input  logic [NREQ-1:0]       req_val,
    output logic [NREQ-1:0]       req_rdy,
    output logic [nbits-1:0]      resp_msg,
    output logic [NREQ-1:0]       resp_val,
    input  logic [NREQ-1:0]       resp_rdy,
    output logic [nbits-1:0]      down_send_msg,
    output logic                  down_send_val,
    input  logic                  down_send_rdy,
    input  logic [nbits-1:0]      down_recv_msg,
    input  logic                  down_recv_val,
    output logic                  down_recv_rdy,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      r_state;
    logic [NREQ-1:0] r_grant;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_prio;
    logic            r_busy;

    logic [NREQ-1:0] w_win;
    logic            w_win_valid;
    logic [IW-1:0]   w_win_idx;
    logic            w_in_send;
    logic            w_in_wait;
    logic            w_send_fire;
    logic            w_resp_fire;

    rr_priority_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .i_req   (req_val),
        .i_prio  (r_prio),
        .o_win   (w_win),
        .o_valid (w_win_valid)
    );

    always_comb begin
        w_win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_win[i]) begin
                w_win_idx = IW'(i);
            end
        end
    end

    assign w_in_send   = (r_state == SEND);
    assign w_in_wait   = (r_state == WAIT);
    assign w_send_fire = w_in_send && down_send_rdy;
    assign w_resp_fire = w_in_wait && down_recv_val && resp_rdy[r_owner];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_prio  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_state <= SEND;
                        r_grant <= w_win;
                        r_owner <= w_win_idx;
                        r_busy  <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_send_fire) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_resp_fire) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_prio  <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Handshakes steer straight through to the owner; nothing is raised outside its phase.
    assign down_send_val = w_in_send;
    assign down_send_msg = w_in_send ? req_msg[r_owner*nbits +: nbits] : '0;
    assign req_rdy       = w_in_send ? (r_grant & {NREQ{down_send_rdy}}) : '0;

    assign down_recv_rdy = w_in_wait && resp_rdy[r_owner];
    assign resp_val      = w_in_wait ? (r_grant & {NREQ{down_recv_val}}) : '0;
    assign resp_msg      = w_in_wait ? down_recv_msg : '0;

    assign grant = r_grant;
    assign busy  = r_busy;

endmodule
